// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised SAP-style accumulator CPU.
//
// One self-contained core with an on-chip program/data RAM, a load port and
// a fixed six-phase one-hot ring sequencer. Every instruction takes exactly
// six cycles: T1..T3 fetch, T4..T6 execute, and unused phases are no-ops.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset (RAM contents are kept)
//   run        0 = load mode (ring held at T1, PC held at 0), 1 = execute
//   prog_we    RAM write strobe, honoured only in load mode
//   prog_addr  load address
//   prog_data  load data
//   out        output register, written by OUT
//   out_valid  high for the one cycle after an OUT has loaded out
//   halted     set by HLT, cleared by clr or by returning to load mode
//   t_state    one-hot phase, bit0 = T1
//   acc        accumulator, for debug
//
// Instruction word: opcode = word[DATA_W-1 -: OPC_W], operand = word[ADDR_W-1:0].

module sap_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              halted,
    output logic [5:0]        t_state,
    output logic [DATA_W-1:0] acc
);

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(14);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(15);

    // One-hot ring encoding doubles as the t_state output.
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } phase_t;

    phase_t phase_q;
    phase_t phase_d;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              z;
    logic              c;

    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] ram_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic [OPC_W-1:0]  opc;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W-1:0] sub_diff;

    // Middle instruction bits are don't-care when DATA_W > OPC_W + ADDR_W.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir;

    assign opc      = ir[DATA_W-1 -: OPC_W];
    assign operand  = ir[ADDR_W-1:0];
    assign ram_rd   = ram[mar];
    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign sub_diff = a - b;

    assign t_state  = phase_q;
    assign acc      = a;

    // ------------------------------------------------------------------
    // Sequencer: held at T1 in load mode, frozen while halted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values and process order cannot matter.
        if (clr) phase_q <= T1;
        else     phase_q <= phase_d;
    end

    always_comb begin
        // NOTE: the default assignment first guarantees a value on every path,
        // so no latch is inferred.
        phase_d = phase_q;
        if (!run) begin
            phase_d = T1;
        end else if (!halted) begin
            case (phase_q)
                T1:      phase_d = T2;
                T2:      phase_d = T3;
                T3:      phase_d = T4;
                T4:      phase_d = T5;
                T5:      phase_d = T6;
                T6:      phase_d = T1;
                default: phase_d = T1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!run) begin
                // Load mode aborts any partial instruction; A, B, flags and
                // out simply hold.
                pc     <= '0;
                halted <= 1'b0;
            end else if (!halted) begin
                case (phase_q)
                    T1: mar <= pc;
                    T2: pc  <= pc + ADDR_W'(1);
                    T3: ir  <= ram_rd;
                    T4: begin
                        case (opc)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                            OP_LDI: begin
                                a <= DATA_W'(operand);
                                z <= (operand == '0);
                            end
                            OP_JMP: pc <= operand;
                            OP_JZ:  if (z) pc <= operand;
                            OP_JC:  if (c) pc <= operand;
                            OP_OUT: begin
                                out       <= a;
                                out_valid <= 1'b1;
                            end
                            OP_HLT: halted <= 1'b1;
                            default: ;
                        endcase
                    end
                    T5: begin
                        case (opc)
                            OP_LDA: begin
                                a <= ram_rd;
                                z <= (ram_rd == '0);
                            end
                            OP_ADD, OP_SUB: b <= ram_rd;
                            default: ;
                        endcase
                    end
                    T6: begin
                        case (opc)
                            OP_ADD: begin
                                {c, a} <= add_sum;
                                z      <= (add_sum[DATA_W-1:0] == '0);
                            end
                            OP_SUB: begin
                                a <= sub_diff;
                                c <= (a >= b);  // unsigned no-borrow
                                z <= (sub_diff == '0);
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM: the load port in load mode, STA at T5 in execute mode. clr blocks
    // the write so a reset landing on STA's T5 leaves memory untouched.
    // ------------------------------------------------------------------
    assign ram_we    = !clr && ((!run && prog_we) ||
                                (run && !halted && phase_q == T5 && opc == OP_STA));
    assign ram_waddr = run ? mar : prog_addr;
    assign ram_wdata = run ? a   : prog_data;

    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset; program contents must survive clr.
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

endmodule

// File: tb/tb_sap_cpu_param.sv
// tb_sap_cpu_param: self-checking bench for sap_cpu_param.
//
// The default 8/4/4 instance runs directed and random programs against an
// instruction-level reference model (one model step per six-cycle
// instruction). A second DATA_W=12 / ADDR_W=8 instance covers the wide
// configuration with fixed expected values.

module tb_sap_cpu_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default-configuration DUT.
    logic       clr, run, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] d_out, d_acc;
    logic       d_out_valid, d_halted;
    logic [5:0] d_t_state;

    sap_cpu_param dut (
        .clk       (clk),
        .clr       (clr),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out       (d_out),
        .out_valid (d_out_valid),
        .halted    (d_halted),
        .t_state   (d_t_state),
        .acc       (d_acc)
    );

    // Wide-configuration DUT.
    logic        w_clr, w_run, w_prog_we;
    logic [7:0]  w_prog_addr;
    logic [11:0] w_prog_data;
    logic [11:0] w_out, w_acc;
    logic        w_out_valid, w_halted;
    logic [5:0]  w_t_state;

    sap_cpu_param #(.DATA_W(12), .ADDR_W(8), .OPC_W(4)) dut_wide (
        .clk       (clk),
        .clr       (w_clr),
        .run       (w_run),
        .prog_we   (w_prog_we),
        .prog_addr (w_prog_addr),
        .prog_data (w_prog_data),
        .out       (w_out),
        .out_valid (w_out_valid),
        .halted    (w_halted),
        .t_state   (w_t_state),
        .acc       (w_acc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (ISA level).
    int m_mem [16];
    int m_a, m_out, m_pc;
    bit m_z, m_c, m_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_a = 0; m_out = 0; m_pc = 0;
        m_z = 0; m_c = 0; m_halt = 0;
    endtask

    // Execute one whole instruction on the model.
    task automatic model_step(output int opc);
        int w, n, m;
        w   = m_mem[m_pc];
        opc = w / 16;
        n   = w % 16;
        m   = m_mem[n];
        m_pc = (m_pc + 1) % 16;
        case (opc)
            0:  begin m_a = m; m_z = (m_a == 0); end
            1:  begin m_a = m_a + m; m_c = (m_a > 255); m_a = m_a % 256; m_z = (m_a == 0); end
            2:  begin m_c = (m_a >= m); m_a = (m_a - m + 256) % 256; m_z = (m_a == 0); end
            3:  m_mem[n] = m_a;
            4:  begin m_a = n; m_z = (n == 0); end
            5:  m_pc = n;
            6:  if (m_z) m_pc = n;
            7:  if (m_c) m_pc = n;
            14: m_out = m_a;
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_acc"},       32'(d_acc), 0);
        check({tag, "_out"},       32'(d_out), 0);
        check({tag, "_out_valid"}, 32'(d_out_valid), 0);
        check({tag, "_halted"},    32'(d_halted), 0);
        check({tag, "_t_state"},   32'(d_t_state), 32'h01);
    endtask

    // Entered at a negedge; clr seen on the next rising edge.
    task automatic do_clr(input string tag);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; run = 1'b0; prog_we = 1'b0;
        check_reset(tag);
        model_reset();
    endtask

    task automatic load_word(input int addr, input int data);
        prog_we = 1'b1; prog_addr = 4'(addr); prog_data = 8'(data);
        m_mem[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic load_image(input int img [16]);
        for (int i = 0; i < 16; i++) load_word(i, img[i]);
    endtask

    // Run from PC=0 for up to max_instr instructions or until HLT, checking
    // phase and out_valid every cycle and architectural state per instruction.
    // prog_we noise is driven throughout to show it is ignored while running.
    task automatic run_prog(input string tag, input int max_instr);
        int  opc;
        bit  done;
        done = 0;
        m_pc = 0;
        run  = 1'b1;
        for (int k = 0; k < max_instr && !done; k++) begin
            model_step(opc);
            for (int cyc = 1; cyc <= ((opc == 15) ? 4 : 6); cyc++) begin
                @(negedge clk);
                check({tag, "_t_state"},   32'(d_t_state), 32'(1) << (cyc % 6));
                check({tag, "_out_valid"}, 32'(d_out_valid), 32'(cyc == 4 && opc == 14));
                prog_we   = 1'($urandom_range(0, 1));
                prog_addr = 4'($urandom);
                prog_data = 8'($urandom);
            end
            check({tag, "_acc"},    32'(d_acc), m_a);
            check({tag, "_out"},    32'(d_out), m_out);
            check({tag, "_halted"}, 32'(d_halted), 32'(m_halt));
            if (opc == 15) begin
                done = 1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check({tag, "_hold_t"},   32'(d_t_state), 32'h10);
                    check({tag, "_hold_ov"},  32'(d_out_valid), 0);
                    check({tag, "_hold_acc"}, 32'(d_acc), m_a);
                    check({tag, "_hold_out"}, 32'(d_out), m_out);
                    check({tag, "_hold_h"},   32'(d_halted), 1);
                end
            end
        end
        prog_we = 1'b0;
        run     = 1'b0;
        @(negedge clk);
        m_halt = 0;
        check({tag, "_load_t"}, 32'(d_t_state), 32'h01);
        check({tag, "_load_h"}, 32'(d_halted), 0);
        check({tag, "_load_acc"}, 32'(d_acc), m_a);
    endtask

    task automatic fill(output int img [16], input int val);
        for (int i = 0; i < 16; i++) img[i] = val;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int img [16];
        int opc;
        int ops [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 14, 15};
        int waddr [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h20, 8'h21, 8'h22};
        int wdata [10] = '{12'h4FF, 12'h210, 12'h720, 12'h620, 12'hE00, 12'hF00,
                           12'h100, 12'h4AA, 12'hE00, 12'hF00};

        clr = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        w_clr = 1'b1; w_run = 1'b0; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
        model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        @(negedge clk);

        // Basic program: 0x10 + 0x14 - 0x18 = 0x0C, OUT on edge 22, HLT on edge 28.
        do_clr("reset");
        fill(img, 8'h80);
        img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h2B; img[3] = 8'hE0; img[4] = 8'hF0;
        img[9] = 8'h10; img[10] = 8'h14; img[11] = 8'h18;
        load_image(img);
        run_prog("basic", 10);
        check("basic_out_value", 32'(d_out), 32'h0C);

        // Carry and jumps: 0x0F + 0xF1 -> A=0, C=1, Z=1; JC and JZ taken,
        // then 0 + 0xF1 clears C so the following JC falls through to OUT.
        do_clr("clr_carry");
        fill(img, 8'hF0);
        img[0] = 8'h4F; img[1] = 8'h19; img[2] = 8'h78;
        img[8] = 8'h6A; img[9] = 8'hF1;
        img[10] = 8'h19; img[11] = 8'h7E; img[12] = 8'hE0;
        load_image(img);
        run_prog("carry", 12);
        check("carry_out_value", 32'(d_out), 32'hF1);

        // Store/load roundtrip through RAM[0xE].
        do_clr("clr_store");
        fill(img, 8'h80);
        img[0] = 8'h45; img[1] = 8'h3E; img[2] = 8'h40; img[3] = 8'h0E;
        img[4] = 8'hE0; img[5] = 8'hF0; img[14] = 8'h77;
        load_image(img);
        run_prog("store", 10);
        check("store_out_value", 32'(d_out), 32'h05);

        // PC wrap 0xF -> 0x0 through a field of NOPs.
        do_clr("clr_wrap");
        fill(img, 8'h80);
        img[0] = 8'hE0; img[15] = 8'h4A;
        load_image(img);
        run_prog("wrap", 18);
        check("wrap_out_value", 32'(d_out), 32'h0A);

        // run dropped at T5 of ADD: ring back to T1, A unchanged, restart at PC 0.
        do_clr("clr_drop");
        fill(img, 8'h80);
        img[0] = 8'h43; img[1] = 8'h1F; img[2] = 8'hE0; img[3] = 8'hF0; img[15] = 8'h04;
        load_image(img);
        run = 1'b1;
        model_step(opc);
        cycles(10);
        check("drop_at_t5", 32'(d_t_state), 32'h10);
        run = 1'b0;
        cycles(1);
        check("drop_t_state", 32'(d_t_state), 32'h01);
        check("drop_acc", 32'(d_acc), 32'h03);
        run_prog("drop_rerun", 6);
        check("drop_out_value", 32'(d_out), 32'h07);

        // clr at T5 of STA: no write to RAM[0xD], all outputs cleared.
        do_clr("clr_sta");
        fill(img, 8'h80);
        img[0] = 8'h47; img[1] = 8'h3D; img[13] = 8'h03;
        load_image(img);
        run = 1'b1;
        model_step(opc);
        cycles(10);
        check("sta_at_t5", 32'(d_t_state), 32'h10);
        check("sta_acc", 32'(d_acc), 32'h07);
        do_clr("sta_reset");
        load_word(0, 8'h0D); load_word(1, 8'hE0); load_word(2, 8'hF0);
        run_prog("sta_verify", 5);
        check("sta_ram_kept", 32'(d_out), 32'h03);

        // Random programs; state carries across runs unless clr is drawn.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) do_clr("rnd_clr");
            for (int i = 0; i < 16; i++) begin
                int op;
                op = ops[$urandom_range(0, 10)];
                if (op == 15 && $urandom_range(0, 2) != 0) op = 4;
                img[i] = op * 16 + $urandom_range(0, 15);
            end
            load_image(img);
            run_prog("rnd", 25);
        end

        // Wide configuration: LDI 0xFF, SUB 0x100 -> 0xFFF, C=0, Z=0.
        w_clr = 1'b1;
        @(negedge clk);
        w_clr = 1'b0;
        check("wide_reset_acc", 32'(w_acc), 0);
        check("wide_reset_t", 32'(w_t_state), 32'h01);
        for (int i = 0; i < 10; i++) begin
            w_prog_we = 1'b1; w_prog_addr = 8'(waddr[i]); w_prog_data = 12'(wdata[i]);
            @(negedge clk);
        end
        w_prog_we = 1'b0;
        w_run = 1'b1;
        cycles(6);
        check("wide_ldi_acc", 32'(w_acc), 32'h0FF);
        cycles(6);
        check("wide_sub_acc", 32'(w_acc), 32'hFFF);
        cycles(16);
        check("wide_out_valid", 32'(w_out_valid), 1);
        check("wide_out", 32'(w_out), 32'hFFF);
        cycles(12);
        check("wide_halted", 32'(w_halted), 1);
        check("wide_halt_t", 32'(w_t_state), 32'h10);
        check("wide_final_out", 32'(w_out), 32'hFFF);
        check("wide_final_acc", 32'(w_acc), 32'hFFF);
        w_run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sap_cpu_param.md
Name: sap_cpu_param

Overview:
- Parametrised successor to the SAP-1 top: one self-contained accumulator CPU with on-chip program/data RAM, a load port, and a fixed 6-phase ring-counter sequencer.
- Generalised in data width and address/memory depth.
- Adds STA, LDI, JMP, JZ, JC, Z/C flags, an out_valid strobe and a halted status.
- Replaces the ch_s2/ch_s4 switch pair with a single run/load mode input.

Parameters:
- DATA_W, 8, accumulator/bus/RAM word width; DATA_W >= OPC_W + ADDR_W.
- ADDR_W, 4, PC/MAR width; RAM depth = 2**ADDR_W.
- OPC_W, 4, opcode field width; opcode = word[DATA_W-1 -: OPC_W], operand = word[ADDR_W-1:0].

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- run  in  1  0 = load mode, 1 = execute
- prog_we  in  1  RAM write strobe, honoured only when run=0
- prog_addr  in  ADDR_W  load address
- prog_data  in  DATA_W  load data
- out  out  DATA_W  output register
- out_valid  out  1  one-cycle pulse after out is loaded
- halted  out  1  HLT executed
- t_state  out  6  one-hot phase T1..T6 (bit0 = T1)
- acc  out  DATA_W  accumulator, for debug

Behaviour:
- Reset:
  - clr=1 at a rising edge has top priority.
  - Clears PC, MAR, IR, A, B, Z, C, out, out_valid and halted, and sets t_state to 6'b000001.
  - RAM contents are preserved.
  - Reset may arrive mid-instruction: that instruction is discarded with no partial RAM write afterwards.
- Load mode (run=0):
  - t_state is held at T1 and PC is held at 0.
  - prog_we=1 writes RAM[prog_addr] <= prog_data on that edge.
  - A, B, flags and out hold; halted clears.
  - A run 1->0 transition aborts any instruction in progress on the next edge.
- Execute mode (run=1, halted=0):
  - The ring advances T1->T2->...->T6->T1 every cycle.
  - Every instruction takes 6 cycles; unused phases are no-ops.
  - prog_we is ignored.
- Fetch phases:
  - T1: MAR <= PC.
  - T2: PC <= PC+1, modulo 2**ADDR_W (0xF wraps to 0x0).
  - T3: IR <= RAM[MAR]. RAM reads are combinational on MAR.
- Execute phases by opcode (operand field = n):
  - 0 LDA: T4 MAR<=n; T5 A<=RAM[MAR], Z updated.
  - 1 ADD: T4 MAR<=n; T5 B<=RAM[MAR]; T6 {C,A}<=A+B (DATA_W+1-bit sum), Z updated.
  - 2 SUB: T4 MAR<=n; T5 B<=RAM[MAR]; T6 A<=A-B mod 2**DATA_W, C<=(A>=B) unsigned no-borrow, Z updated.
  - 3 STA: T4 MAR<=n; T5 RAM[MAR]<=A.
  - 4 LDI: T4 A<=zero-extended n, Z updated.
  - 5 JMP: T4 PC<=n.
  - 6 JZ: T4 PC<=n if Z=1.
  - 7 JC: T4 PC<=n if C=1.
  - E OUT: T4 out<=A; out_valid=1 during the following cycle only.
  - F HLT: T4 halted<=1.
  - All other opcodes are NOPs.
- Flags:
  - Z = (result == 0).
  - C is written only by ADD/SUB.
  - Both flags hold otherwise.
- Halt:
  - Once halted=1, the ring freezes at its current phase (T5) and no register or RAM changes occur.
  - out holds its value.
  - Only clr or run=0 exits halt.
- out_valid is 0 in every cycle except the one following an OUT T4 edge.
- Simultaneous events: a RAM write (STA) and a read never coincide, because the sequencer serialises them.

Test Plan:
- Basic program, DATA_W=8: RAM = {0:0x09 LDA 9, 1:0x1A ADD A, 2:0x2B SUB B, 3:0xE0 OUT, 4:0xF0 HLT, 9:0x10, A:0x14, B:0x18}; clr, then run=1.
  - out = 0x0C with out_valid pulsed once, following rising edge 22 after run rises.
  - halted = 1 after edge 28; state stable for 10 further cycles.
- Carry and jump: LDI 0xF (A=0x0F), ADD of RAM 0xF1.
  - A = 0x00, C=1, Z=1.
  - A following JC 0x8 lands PC = 8; JZ also taken.
  - An untaken JC with C=0 continues at PC+1.
- Store/load roundtrip: LDI 5, STA 0xE, LDI 0, LDA 0xE -> A = 0x05, RAM[0xE] = 0x05.
- Mode and reset:
  - prog_we with run=1 leaves RAM unchanged.
  - run dropped at T5 of ADD -> t_state = T1 and PC = 0 next cycle; A unchanged.
  - clr asserted at T5 of STA -> RAM untouched, all outputs zero, t_state = 000001.
- Wrap: PC runs through 0xF -> 0x0 with NOPs.
- Wide config, DATA_W=12, ADDR_W=8: LDI 0xFF -> acc = 0x0FF.
- Wide subtraction: SUB of 0x100 from 0x0FF -> A = 0xFFF, C=0, Z=0.
